// File: rtl/fiber_cmd_ctrl.sv
// fiber_cmd_ctrl
// Link/command supervisor behind the fiber receive parity checker.
// It acquires the link (LOCK_N consecutive good frames), then applies a
// command once CONFIRM_N identical consecutive good frames have been seen.
// A time_1us-driven watchdog and the latched parity fault force the FAULT
// state, which drives SAFE_CMD until reset_unit is asserted.
//
// Optional feature macro: FIBER_CMD_HEARTBEAT_EN
//   When defined, a good frame carrying HB_CODE in ACTIVE only feeds the
//   watchdog and is never applied. When undefined, HB_CODE is not a
//   parameter and every code is an ordinary command.
//
// Ports:
//   clk           system clock
//   rst_n         synchronous active-low reset
//   time_1us      one-clk strobe every microsecond
//   frame_end     one-clk strobe, frame reception finished
//   frame_valid   frame parity good (qualified by frame_end)
//   frame_data    frame payload (CMD_W bits)
//   verify_err    latched parity-error fault from the checker
//   reset_unit    fault clear / re-acquire request
//   cmd_out       applied command
//   cmd_valid     one-clk pulse when cmd_out changes value
//   link_ok       high in ACTIVE
//   link_lost_err latched watchdog fault
//   fault_out     high in FAULT
//   state_out     00 LINK_WAIT, 01 ACTIVE, 10 FAULT
module fiber_cmd_ctrl #(
  parameter int CMD_W = 4,
  parameter int LOCK_N = 8,
  parameter int CONFIRM_N = 2,
  parameter int TIMEOUT_US = 200,
  parameter logic [CMD_W-1:0] SAFE_CMD = '0
`ifdef FIBER_CMD_HEARTBEAT_EN
  ,
  parameter logic [CMD_W-1:0] HB_CODE = '1
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             time_1us,
  input  logic             frame_end,
  input  logic             frame_valid,
  input  logic [CMD_W-1:0] frame_data,
  input  logic             verify_err,
  input  logic             reset_unit,
  output logic [CMD_W-1:0] cmd_out,
  output logic             cmd_valid,
  output logic             link_ok,
  output logic             link_lost_err,
  output logic             fault_out,
  output logic [1:0]       state_out
);

  localparam int LW = $clog2(LOCK_N + 1);
  localparam int RW = $clog2(CONFIRM_N + 1);
  localparam int WW = $clog2(TIMEOUT_US + 1);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_N - 1);
  localparam logic [RW-1:0] RUN_MAX   = RW'(CONFIRM_N);
  localparam logic [RW-1:0] RUN_ONE   = RW'(1);
  localparam logic [WW-1:0] WD_MAX    = WW'(TIMEOUT_US);
  localparam logic [WW-1:0] WD_ONE    = WW'(1);
  localparam logic [LW-1:0] LOCK_ONE  = LW'(1);

  typedef enum logic [1:0] {
    LINK_WAIT = 2'b00,
    ACTIVE    = 2'b01,
    FAULT     = 2'b10
  } state_t;

  state_t           state, state_nxt;
  logic [LW-1:0]    lock_cnt, lock_nxt;
  logic [RW-1:0]    run_cnt, run_nxt, run_inc;
  logic [WW-1:0]    wd_cnt, wd_nxt;
  logic [CMD_W-1:0] prev_data, prev_nxt;
  logic [CMD_W-1:0] cmd_nxt;
  logic             valid_nxt, lost_nxt;
  logic             good, bad, expired, is_hb;

  assign good    = frame_end & frame_valid;
  assign bad     = frame_end & ~frame_valid;
  assign expired = (wd_cnt == WD_MAX);

`ifdef FIBER_CMD_HEARTBEAT_EN
  assign is_hb = (frame_data == HB_CODE);
`else
  assign is_hb = 1'b0;
`endif

  assign link_ok   = (state == ACTIVE);
  assign fault_out = (state == FAULT);
  assign state_out = state;

  // Next-state and datapath decisions. Run tracking also happens during
  // acquisition so that the frame completing lock can already confirm a
  // command; that command is applied on the same edge that enters ACTIVE.
  always_comb begin
    state_nxt = state;
    lock_nxt  = lock_cnt;
    run_nxt   = run_cnt;
    wd_nxt    = wd_cnt;
    prev_nxt  = prev_data;
    cmd_nxt   = cmd_out;
    valid_nxt = 1'b0;
    lost_nxt  = link_lost_err;

    // run length including the current frame, saturating at CONFIRM_N
    if (frame_data == prev_data) begin
      run_inc = (run_cnt == RUN_MAX) ? RUN_MAX : run_cnt + RUN_ONE;
    end else begin
      run_inc = RUN_ONE;
    end

    if (reset_unit) begin
      state_nxt = LINK_WAIT;
      lock_nxt  = '0;
      run_nxt   = '0;
      wd_nxt    = '0;
      lost_nxt  = 1'b0;
      cmd_nxt   = SAFE_CMD;
    end else begin
      case (state)
        LINK_WAIT, ACTIVE: begin
          if (verify_err || expired) begin
            // both fault causes are recorded when they coincide
            state_nxt = FAULT;
            lost_nxt  = link_lost_err | expired;
            cmd_nxt   = SAFE_CMD;
            valid_nxt = (cmd_out != SAFE_CMD);
            lock_nxt  = '0;
            run_nxt   = '0;
            wd_nxt    = '0;
          end else begin
            // a good frame wins over a simultaneous tick
            if (good) begin
              wd_nxt = '0;
            end else if (time_1us && !expired) begin
              wd_nxt = wd_cnt + WD_ONE;
            end

            if (bad) begin
              lock_nxt = '0;
              run_nxt  = '0;
            end else if (good && state == LINK_WAIT) begin
              prev_nxt = frame_data;
              run_nxt  = run_inc;
              if (lock_cnt == LOCK_LAST) begin
                state_nxt = ACTIVE;
                lock_nxt  = '0;
                wd_nxt    = '0;
                if (run_inc == RUN_MAX && frame_data != cmd_out) begin
                  cmd_nxt   = frame_data;
                  valid_nxt = 1'b1;
                end
              end else begin
                lock_nxt = lock_cnt + LOCK_ONE;
              end
            end else if (good && !is_hb) begin
              prev_nxt = frame_data;
              run_nxt  = run_inc;
              if (run_inc == RUN_MAX && frame_data != cmd_out) begin
                cmd_nxt   = frame_data;
                valid_nxt = 1'b1;
              end
            end
          end
        end
        FAULT: begin
          // frames ignored; only reset_unit leaves FAULT
        end
        default: begin
          state_nxt = LINK_WAIT;
          cmd_nxt   = SAFE_CMD;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= LINK_WAIT;
      lock_cnt      <= '0;
      run_cnt       <= '0;
      wd_cnt        <= '0;
      prev_data     <= SAFE_CMD;
      cmd_out       <= SAFE_CMD;
      cmd_valid     <= 1'b0;
      link_lost_err <= 1'b0;
    end else begin
      state         <= state_nxt;
      lock_cnt      <= lock_nxt;
      run_cnt       <= run_nxt;
      wd_cnt        <= wd_nxt;
      prev_data     <= prev_nxt;
      cmd_out       <= cmd_nxt;
      cmd_valid     <= valid_nxt;
      link_lost_err <= lost_nxt;
    end
  end

endmodule

// File: tb/tb_fiber_cmd_ctrl.sv
// Self-checking bench for fiber_cmd_ctrl: a table of directed vectors,
// hand-written watchdog / reset / heartbeat sequences, then randomized
// traffic compared against a frame-history reference model.
module tb_fiber_cmd_ctrl;

  localparam int LOCK_N     = 8;
  localparam int CONFIRM_N  = 2;
  localparam int TIMEOUT_US = 200;

  localparam logic [1:0] S_WAIT   = 2'b00;
  localparam logic [1:0] S_ACTIVE = 2'b01;
  localparam logic [1:0] S_FAULT  = 2'b10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       time_1us;
  logic       frame_end;
  logic       frame_valid;
  logic [3:0] frame_data;
  logic       verify_err;
  logic       reset_unit;
  logic [3:0] cmd_out;
  logic       cmd_valid;
  logic       link_ok;
  logic       link_lost_err;
  logic       fault_out;
  logic [1:0] state_out;

  int checks = 0;
  int failures = 0;

  fiber_cmd_ctrl dut (
    .clk(clk),
    .rst_n(rst_n),
    .time_1us(time_1us),
    .frame_end(frame_end),
    .frame_valid(frame_valid),
    .frame_data(frame_data),
    .verify_err(verify_err),
    .reset_unit(reset_unit),
    .cmd_out(cmd_out),
    .cmd_valid(cmd_valid),
    .link_ok(link_ok),
    .link_lost_err(link_lost_err),
    .fault_out(fault_out),
    .state_out(state_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       fe;
    logic       fv;
    logic [3:0] fd;
    logic       ve;
    logic       ru;
    logic       tk;
    logic [1:0] es;
    logic [3:0] ec;
    logic       ev;
    logic       el;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_vec(input logic fe, fv, input logic [3:0] fd,
                                  input logic ve, ru, tk, input logic [1:0] es,
                                  input logic [3:0] ec, input logic ev, el);
    vec_t v;
    v.fe = fe; v.fv = fv; v.fd = fd; v.ve = ve; v.ru = ru; v.tk = tk;
    v.es = es; v.ec = ec; v.ev = ev; v.el = el;
    vecs.push_back(v);
  endfunction

  // drive one clock worth of inputs; outputs are sampled 1 time unit later
  task automatic applyStimulus(input logic fe, fv, input logic [3:0] fd,
                               input logic ve, ru, tk);
    frame_end   = fe;
    frame_valid = fv;
    frame_data  = fd;
    verify_err  = ve;
    reset_unit  = ru;
    time_1us    = tk;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [1:0] es,
                             input logic [3:0] ec, input logic ev, el);
    logic [9:0] act;
    logic [9:0] expv;
    act  = {state_out, link_ok, fault_out, link_lost_err, cmd_valid, cmd_out};
    expv = {es, es == S_ACTIVE, es == S_FAULT, el, ev, ec};
    checks++;
    if (act !== expv) begin
      failures++;
      $display("[TB] FAIL %s: got state=%b ok=%b fault=%b lost=%b valid=%b cmd=%h, want state=%b ok=%b fault=%b lost=%b valid=%b cmd=%h",
               name, state_out, link_ok, fault_out, link_lost_err, cmd_valid, cmd_out,
               es, es == S_ACTIVE, es == S_FAULT, el, ev, ec);
    end
  endtask

  task automatic hard_reset();
    rst_n = 1'b0;
    repeat (3) applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("reset", S_WAIT, 4'h0, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  // Reference model: tracks the recent good-frame history, a count of
  // frames toward lock and elapsed microseconds since the last good frame.
  logic [1:0] m_state;
  int         m_lock;
  int         m_wd;
  logic [3:0] m_cmd;
  logic       m_valid;
  logic       m_lost;
  logic [3:0] m_hist[$];

  function automatic logic m_is_hb(input logic [3:0] d);
`ifdef FIBER_CMD_HEARTBEAT_EN
    return d == 4'hF;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic m_confirmed();
    int n;
    n = m_hist.size();
    if (n < CONFIRM_N) return 1'b0;
    for (int i = 1; i < CONFIRM_N; i++)
      if (m_hist[n-1-i] != m_hist[n-1]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void m_record(input logic [3:0] d);
    m_hist.push_back(d);
    if (m_hist.size() > CONFIRM_N) void'(m_hist.pop_front());
    if (m_confirmed() && d != m_cmd) begin
      m_cmd   = d;
      m_valid = 1'b1;
    end
  endfunction

  function automatic void m_reset();
    m_state = S_WAIT; m_lock = 0; m_wd = 0; m_cmd = 4'h0;
    m_valid = 1'b0; m_lost = 1'b0; m_hist.delete();
  endfunction

  function automatic void m_step(input logic fe, fv, input logic [3:0] fd,
                                 input logic ve, ru, tk);
    logic good;
    logic bad;
    good = fe && fv;
    bad  = fe && !fv;
    m_valid = 1'b0;
    if (ru) begin
      m_state = S_WAIT; m_lock = 0; m_wd = 0; m_lost = 1'b0;
      m_cmd = 4'h0; m_hist.delete();
    end else if (m_state != S_FAULT && (ve || m_wd == TIMEOUT_US)) begin
      if (m_wd == TIMEOUT_US) m_lost = 1'b1;
      m_valid = (m_cmd != 4'h0);
      m_cmd = 4'h0;
      m_state = S_FAULT; m_lock = 0; m_wd = 0; m_hist.delete();
    end else if (m_state != S_FAULT) begin
      if (good) m_wd = 0;
      else if (tk && m_wd < TIMEOUT_US) m_wd++;
      if (bad) begin
        m_lock = 0;
        m_hist.delete();
      end else if (good && m_state == S_WAIT) begin
        m_lock++;
        if (m_lock == LOCK_N) begin
          m_state = S_ACTIVE; m_lock = 0; m_wd = 0;
          m_record(fd);
        end else begin
          m_hist.push_back(fd);
          if (m_hist.size() > CONFIRM_N) void'(m_hist.pop_front());
        end
      end else if (good && !m_is_hb(fd)) begin
        m_record(fd);
      end
    end
  endfunction

  initial begin
    logic [3:0] dpick;
    logic fe, fv, ve, ru, tk;
    int quiet;

    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);

    // acquisition with 3s: last two frames confirm 3 on the locking edge
    for (int i = 0; i < 7; i++) add_vec(1, 1, 4'h3, 0, 0, 0, S_WAIT, 4'h0, 0, 0);
    add_vec(1, 1, 4'h3, 0, 0, 0, S_ACTIVE, 4'h3, 1, 0);
    add_vec(0, 0, 4'h0, 0, 0, 0, S_ACTIVE, 4'h3, 0, 0);
    // alternating 5/3 is never applied; 5,5 is
    add_vec(1, 1, 4'h5, 0, 0, 0, S_ACTIVE, 4'h3, 0, 0);
    add_vec(1, 1, 4'h3, 0, 0, 0, S_ACTIVE, 4'h3, 0, 0);
    add_vec(1, 1, 4'h5, 0, 0, 0, S_ACTIVE, 4'h3, 0, 0);
    add_vec(1, 1, 4'h5, 0, 0, 0, S_ACTIVE, 4'h5, 1, 0);
    add_vec(0, 0, 4'h0, 0, 0, 0, S_ACTIVE, 4'h5, 0, 0);
    add_vec(1, 1, 4'h5, 0, 0, 0, S_ACTIVE, 4'h5, 0, 0);
    // a bad frame breaks the run of 9s
    add_vec(1, 1, 4'h9, 0, 0, 0, S_ACTIVE, 4'h5, 0, 0);
    add_vec(1, 0, 4'h9, 0, 0, 0, S_ACTIVE, 4'h5, 0, 0);
    add_vec(1, 1, 4'h9, 0, 0, 0, S_ACTIVE, 4'h5, 0, 0);
    add_vec(1, 1, 4'h9, 0, 0, 0, S_ACTIVE, 4'h9, 1, 0);
    // HB code: heartbeat only with the feature, otherwise a plain command
    add_vec(1, 1, 4'hF, 0, 0, 0, S_ACTIVE, 4'h9, 0, 0);
`ifdef FIBER_CMD_HEARTBEAT_EN
    add_vec(1, 1, 4'hF, 0, 0, 0, S_ACTIVE, 4'h9, 0, 0);
`else
    add_vec(1, 1, 4'hF, 0, 0, 0, S_ACTIVE, 4'hF, 1, 0);
`endif
    // parity fault, frames ignored in FAULT, reset_unit back to LINK_WAIT
    add_vec(0, 0, 4'h0, 1, 0, 0, S_FAULT, 4'h0, 1, 0);
    add_vec(1, 1, 4'h3, 0, 0, 0, S_FAULT, 4'h0, 0, 0);
    add_vec(0, 0, 4'h0, 0, 0, 1, S_FAULT, 4'h0, 0, 0);
    add_vec(0, 0, 4'h0, 0, 1, 0, S_WAIT, 4'h0, 0, 0);
    add_vec(0, 0, 4'h0, 0, 0, 0, S_WAIT, 4'h0, 0, 0);
    // verify_err still high after reset_unit: re-enter FAULT, no pulse
    add_vec(0, 0, 4'h0, 1, 1, 0, S_WAIT, 4'h0, 0, 0);
    add_vec(0, 0, 4'h0, 1, 0, 0, S_FAULT, 4'h0, 0, 0);
    add_vec(0, 0, 4'h0, 0, 1, 0, S_WAIT, 4'h0, 0, 0);
    // 6 good, 1 bad, 8 good: ACTIVE only after the 15th frame
    for (int i = 0; i < 6; i++) add_vec(1, 1, 4'h7, 0, 0, 0, S_WAIT, 4'h0, 0, 0);
    add_vec(1, 0, 4'h7, 0, 0, 0, S_WAIT, 4'h0, 0, 0);
    for (int i = 0; i < 7; i++) add_vec(1, 1, 4'h7, 0, 0, 0, S_WAIT, 4'h0, 0, 0);
    add_vec(1, 1, 4'h7, 0, 0, 0, S_ACTIVE, 4'h7, 1, 0);
    // frame_valid without frame_end is not a frame
    add_vec(0, 1, 4'h5, 0, 0, 0, S_ACTIVE, 4'h7, 0, 0);

    hard_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].fe, vecs[i].fv, vecs[i].fd, vecs[i].ve, vecs[i].ru, vecs[i].tk);
      checkOutput($sformatf("vec%0d", i), vecs[i].es, vecs[i].ec, vecs[i].ev, vecs[i].el);
    end

    // watchdog: a good frame on the 200th tick keeps ACTIVE
    repeat (TIMEOUT_US - 1) applyStimulus(0, 0, 4'h0, 0, 0, 1);
    applyStimulus(1, 1, 4'h7, 0, 0, 1);
    checkOutput("wd_frame_on_200th", S_ACTIVE, 4'h7, 0, 0);
    repeat (TIMEOUT_US - 1) applyStimulus(0, 0, 4'h0, 0, 0, 1);
    checkOutput("wd_199", S_ACTIVE, 4'h7, 0, 0);
    applyStimulus(0, 0, 4'h0, 0, 0, 1);
    checkOutput("wd_200", S_ACTIVE, 4'h7, 0, 0);
    applyStimulus(0, 0, 4'h0, 0, 0, 0);
    checkOutput("wd_fault", S_FAULT, 4'h0, 1, 1);
    applyStimulus(0, 0, 4'h0, 0, 0, 0);
    checkOutput("wd_fault_hold", S_FAULT, 4'h0, 0, 1);
    applyStimulus(0, 0, 4'h0, 0, 1, 0);
    checkOutput("wd_reset_unit", S_WAIT, 4'h0, 0, 0);

    // rst_n low while a frame ends: frame is not applied
    for (int i = 0; i < LOCK_N; i++) applyStimulus(1, 1, 4'h5, 0, 0, 0);
    checkOutput("relock_5", S_ACTIVE, 4'h5, 1, 0);
    applyStimulus(1, 1, 4'h3, 0, 0, 0);
    rst_n = 1'b0;
    applyStimulus(1, 1, 4'h3, 0, 0, 0);
    checkOutput("rst_mid_frame", S_WAIT, 4'h0, 0, 0);
    rst_n = 1'b1;
    applyStimulus(0, 0, 4'h0, 0, 0, 0);
    checkOutput("rst_mid_frame_after", S_WAIT, 4'h0, 0, 0);

`ifdef FIBER_CMD_HEARTBEAT_EN
    // heartbeat every 100 us for 1 ms keeps the link without applying
    for (int i = 0; i < LOCK_N; i++) applyStimulus(1, 1, 4'h3, 0, 0, 0);
    checkOutput("hb_lock", S_ACTIVE, 4'h3, 1, 0);
    for (int k = 0; k < 10; k++) begin
      repeat (99) applyStimulus(0, 0, 4'h0, 0, 0, 1);
      applyStimulus(1, 1, 4'hF, 0, 0, 1);
      checkOutput($sformatf("hb%0d", k), S_ACTIVE, 4'h3, 0, 0);
    end
`endif

    // randomized traffic against the reference model
    rst_n = 1'b0;
    applyStimulus(0, 0, 4'h0, 0, 0, 0);
    rst_n = 1'b1;
    m_reset();
    quiet = 0;
    for (int c = 0; c < 5000; c++) begin
      case ($urandom_range(0, 4))
        0: dpick = 4'h3;
        1: dpick = 4'h5;
        2: dpick = 4'h9;
        3: dpick = 4'hF;
        default: dpick = 4'h0;
      endcase
      if (quiet == 0 && $urandom_range(0, 399) == 0) quiet = 220;
      if (quiet > 0) begin
        quiet--;
        fe = 1'b0; fv = 1'b0; ve = 1'b0; ru = 1'b0; tk = 1'b1;
      end else begin
        fe = ($urandom_range(0, 1) == 0);
        fv = ($urandom_range(0, 7) != 0);
        ve = ($urandom_range(0, 79) == 0);
        ru = ($urandom_range(0, 59) == 0);
        tk = ($urandom_range(0, 3) == 0);
      end
      m_step(fe, fv, dpick, ve, ru, tk);
      applyStimulus(fe, fv, dpick, ve, ru, tk);
      checkOutput($sformatf("rand%0d", c), m_state, m_cmd, m_valid, m_lost);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
